compare_event_monitor: RTL and testbench
========================================

# compare_event_monitor

Sequential stage that consumes the Equal/Greater/Lesser result flags of the N-bit comparator one sample at a time. It qualifies a comparison outcome only after the outcome persists for a programmable number of consecutive valid samples. It reports the qualified relation and a change pulse, keeps saturating per-class sample counters, and flags malformed (non-one-hot) flag inputs. It sits directly downstream of the comparator; its outputs feed control/status logic.

## Interface
- PERSIST, 4: consecutive identical valid samples required to qualify a relation; legal range 1..15.
- CNT_W, 8: width of each saturating sample counter.

- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- cmp_valid  input  1  sample strobe; Equal/Greater/Lesser are sampled only when high.
- Equal  input  1  comparator flag, in_1 == in_2.
- Greater  input  1  comparator flag, in_1 > in_2.
- Lesser  input  1  comparator flag, in_1 < in_2.
- clear  input  1  synchronous clear of state, counters and err.
- state  output  2  qualified relation: 00 UNKNOWN, 01 EQ, 10 GT, 11 LT.
- eq_q / gt_q / lt_q  output  1 each  registered decode of state.
- chg  output  1  one-cycle pulse when state changes value.
- eq_cnt / gt_cnt / lt_cnt  output  CNT_W each  saturating counts of valid one-hot samples per class.
- err  output  1  sticky; set by any valid sample whose flags are not exactly one-hot.

## Operation
- Internal registers:
  - cand (2 bits, same encoding as state): candidate relation.
  - run (4 bits): consecutive count for cand.
- Valid one-hot sample with class C:
  - If C == cand: run <= min(run+1, PERSIST).
  - Else: cand <= C, run <= 1.
  - The counter for class C increments unless already at 2^CNT_W-1, where it holds.
- Qualification is evaluated on the updated run value. If updated run == PERSIST and C != state:
  - state <= C.
  - chg <= 1 for that cycle only.
  - eq_q/gt_q/lt_q follow state.
- PERSIST=1: every valid sample whose class differs from state qualifies immediately.
- cmp_valid low: cand, run, state and counters all hold. Gaps do not break a run.
- Valid non-one-hot sample (000, 011, 101, 110, 111):
  - err <= 1 (sticky).
  - run <= 0, cand <= UNKNOWN.
  - Counters and state are unchanged.
- clear high:
  - state, cand <= UNKNOWN; run, all counters, err, chg <= 0.
  - clear overrides a same-cycle sample; that sample is dropped entirely.
- A run never qualifies UNKNOWN; state returns to UNKNOWN only via clear or rst.

## Timing
- rst asserted, asynchronously:
  - state=00; eq_q=gt_q=lt_q=0; chg=0; eq_cnt=gt_cnt=lt_cnt=0; err=0.
  - Internally: cand=00, run=0.
- rst deasserted: operation begins at the first following rising edge.
- Latency: the PERSIST-th qualifying sample is presented in cycle k; state, the *_q outputs and chg update at the edge ending cycle k (visible in cycle k+1). chg is high for exactly one cycle.
- Counters are visible one cycle after their sample.
- err is visible one cycle after the offending sample.
- Back-to-back valid samples every cycle are supported; there is no backpressure.
- rst mid-run discards the partial run; no chg pulse is generated by reset.
- Re-qualifying the current state (run reaches PERSIST again with C == state) produces no chg.

## Test plan
- Reset: assert rst with random inputs -> all outputs 0 and state=00 immediately, without waiting for a clock edge.
- Qualify, PERSIST=4: four valid GT samples (Greater=1) on consecutive cycles -> state=10 and gt_q=1 in the cycle after the 4th sample; chg high for exactly that one cycle; gt_cnt=4.
- Gaps and glitch:
  - GT, GT, gap (cmp_valid=0 for 3 cycles), GT, GT -> state=10.
  - GT, GT, GT, EQ, GT, GT, GT -> state stays 00; eq_cnt=1, gt_cnt=6.
- Saturation, CNT_W=3: ten valid LT samples -> lt_cnt stops at 7; state=11 after the 4th sample.
- Malformed input: valid sample with flags 011 mid-run -> err=1 and stays 1; run restarts, so state needs 4 further GT samples; counters unchanged by the bad sample.
- Clear priority: clear=1 together with a valid EQ sample while state=10 -> next cycle state=00, eq_cnt=0, err=0, chg=0.

Source files
------------

// File: rtl/compare_event_monitor.sv
// Qualifies comparator Equal/Greater/Lesser outcomes after PERSIST consecutive valid samples.
// Also keeps saturating per-class counters and a sticky malformed-input flag.
module compare_event_monitor #(
   parameter int unsigned PERSIST = 4,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmp_valid,
   input  logic             Equal,
   input  logic             Greater,
   input  logic             Lesser,
   input  logic             clear,
   output logic [1:0]       state,
   output logic             eq_q,
   output logic             gt_q,
   output logic             lt_q,
   output logic             chg,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic             err
);

   localparam logic [1:0] ST_UNK = 2'b00;
   localparam logic [1:0] ST_EQ  = 2'b01;
   localparam logic [1:0] ST_GT  = 2'b10;
   localparam logic [1:0] ST_LT  = 2'b11;

   localparam logic [3:0]       PERSIST_V = 4'(PERSIST);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [1:0]       cand, cand_d;
   logic [3:0]       run, run_d, run_upd;
   logic [1:0]       state_d;
   logic             chg_d;
   logic             err_d;
   logic [CNT_W-1:0] eq_cnt_d, gt_cnt_d, lt_cnt_d;
   logic [2:0]       flags;
   logic             one_hot;
   logic [1:0]       cls;

   assign flags = {Equal, Greater, Lesser};

   always_comb begin
      one_hot = 1'b1;
      cls     = ST_UNK;
      unique case (flags)
         3'b100:  cls = ST_EQ;
         3'b010:  cls = ST_GT;
         3'b001:  cls = ST_LT;
         default: one_hot = 1'b0;
      endcase
   end

   // Run saturates at PERSIST so a long steady run can re-qualify without overflow.
   always_comb begin
      if (cls == cand) begin
         run_upd = (run < PERSIST_V) ? run + 4'd1 : PERSIST_V;
      end else begin
         run_upd = 4'd1;
      end
   end

   always_comb begin
      cand_d   = cand;
      run_d    = run;
      state_d  = state;
      chg_d    = 1'b0;
      err_d    = err;
      eq_cnt_d = eq_cnt;
      gt_cnt_d = gt_cnt;
      lt_cnt_d = lt_cnt;
      if (clear) begin
         cand_d   = ST_UNK;
         run_d    = 4'd0;
         state_d  = ST_UNK;
         err_d    = 1'b0;
         eq_cnt_d = '0;
         gt_cnt_d = '0;
         lt_cnt_d = '0;
      end else if (cmp_valid) begin
         if (one_hot) begin
            cand_d = cls;
            run_d  = run_upd;
            if (run_upd == PERSIST_V && cls != state) begin
               state_d = cls;
               chg_d   = 1'b1;
            end
            unique case (cls)
               ST_EQ:   if (eq_cnt != CNT_MAX) eq_cnt_d = eq_cnt + CNT_ONE;
               ST_GT:   if (gt_cnt != CNT_MAX) gt_cnt_d = gt_cnt + CNT_ONE;
               default: if (lt_cnt != CNT_MAX) lt_cnt_d = lt_cnt + CNT_ONE;
            endcase
         end else begin
            err_d  = 1'b1;
            run_d  = 4'd0;
            cand_d = ST_UNK;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand   <= ST_UNK;
         run    <= 4'd0;
         state  <= ST_UNK;
         eq_q   <= 1'b0;
         gt_q   <= 1'b0;
         lt_q   <= 1'b0;
         chg    <= 1'b0;
         err    <= 1'b0;
         eq_cnt <= '0;
         gt_cnt <= '0;
         lt_cnt <= '0;
      end else begin
         cand   <= cand_d;
         run    <= run_d;
         state  <= state_d;
         eq_q   <= (state_d == ST_EQ);
         gt_q   <= (state_d == ST_GT);
         lt_q   <= (state_d == ST_LT);
         chg    <= chg_d;
         err    <= err_d;
         eq_cnt <= eq_cnt_d;
         gt_cnt <= gt_cnt_d;
         lt_cnt <= lt_cnt_d;
      end
   end

endmodule

// File: tb/tb_compare_event_monitor.sv
// Directed bench: a vector table for the default monitor plus hand sequences for
// counter saturation (CNT_W=3), PERSIST=1 and asynchronous reset.
module tb_compare_event_monitor;

   localparam logic [2:0] EQ = 3'b100;
   localparam logic [2:0] GT = 3'b010;
   localparam logic [2:0] LT = 3'b001;
   localparam logic [2:0] NO = 3'b000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmp_valid = 1'b0;
   logic Equal = 1'b0, Greater = 1'b0, Lesser = 1'b0;
   logic clear = 1'b0;

   logic [1:0] state, state_s, state_p;
   logic       eq_q, gt_q, lt_q, eq_q_s, gt_q_s, lt_q_s, eq_q_p, gt_q_p, lt_q_p;
   logic       chg, chg_s, chg_p, err, err_s, err_p;
   logic [7:0] eq_cnt, gt_cnt, lt_cnt, eq_cnt_p, gt_cnt_p, lt_cnt_p;
   logic [2:0] eq_cnt_s, gt_cnt_s, lt_cnt_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   compare_event_monitor #(.PERSIST(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cmp_valid(cmp_valid), .Equal(Equal), .Greater(Greater),
      .Lesser(Lesser), .clear(clear), .state(state), .eq_q(eq_q), .gt_q(gt_q), .lt_q(lt_q),
      .chg(chg), .eq_cnt(eq_cnt), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .err(err)
   );

   compare_event_monitor #(.PERSIST(4), .CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .cmp_valid(cmp_valid), .Equal(Equal), .Greater(Greater),
      .Lesser(Lesser), .clear(clear), .state(state_s), .eq_q(eq_q_s), .gt_q(gt_q_s),
      .lt_q(lt_q_s), .chg(chg_s), .eq_cnt(eq_cnt_s), .gt_cnt(gt_cnt_s), .lt_cnt(lt_cnt_s),
      .err(err_s)
   );

   compare_event_monitor #(.PERSIST(1), .CNT_W(8)) dut_p (
      .clk(clk), .rst(rst), .cmp_valid(cmp_valid), .Equal(Equal), .Greater(Greater),
      .Lesser(Lesser), .clear(clear), .state(state_p), .eq_q(eq_q_p), .gt_q(gt_q_p),
      .lt_q(lt_q_p), .chg(chg_p), .eq_cnt(eq_cnt_p), .gt_cnt(gt_cnt_p), .lt_cnt(lt_cnt_p),
      .err(err_p)
   );

   typedef struct {
      logic       v;
      logic [2:0] f;
      logic       c;
      logic [1:0] st;
      logic       chg;
      logic [7:0] ec;
      logic [7:0] gc;
      logic [7:0] lc;
      logic       e;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic [2:0] f, input logic c, input logic [1:0] st,
                      input logic ch, input int ec, input int gc, input int lc, input logic e);
      vec_t x;
      x.v = v; x.f = f; x.c = c; x.st = st; x.chg = ch;
      x.ec = 8'(ec); x.gc = 8'(gc); x.lc = 8'(lc); x.e = e;
      tbl.push_back(x);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [2:0] f, input logic c);
      @(negedge clk);
      cmp_valid = v;
      {Equal, Greater, Lesser} = f;
      clear = c;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] decode(input logic [1:0] st);
      return {st == 2'b01, st == 2'b10, st == 2'b11};
   endfunction

   initial begin
      // qualify GT, hold on invalid, re-qualify without chg, clear beats EQ
      add(1, GT, 0, 0, 0, 0, 1, 0, 0);
      add(1, GT, 0, 0, 0, 0, 2, 0, 0);
      add(1, GT, 0, 0, 0, 0, 3, 0, 0);
      add(1, GT, 0, 2, 1, 0, 4, 0, 0);
      add(0, GT, 0, 2, 0, 0, 4, 0, 0);
      add(1, GT, 0, 2, 0, 0, 5, 0, 0);
      add(1, EQ, 1, 0, 0, 0, 0, 0, 0);
      // glitch breaks the run
      add(1, GT, 0, 0, 0, 0, 1, 0, 0);
      add(1, GT, 0, 0, 0, 0, 2, 0, 0);
      add(1, GT, 0, 0, 0, 0, 3, 0, 0);
      add(1, EQ, 0, 0, 0, 1, 3, 0, 0);
      add(1, GT, 0, 0, 0, 1, 4, 0, 0);
      add(1, GT, 0, 0, 0, 1, 5, 0, 0);
      add(1, GT, 0, 0, 0, 1, 6, 0, 0);
      add(1, GT, 0, 2, 1, 1, 7, 0, 0);
      add(0, NO, 1, 0, 0, 0, 0, 0, 0);
      // gaps do not break a run
      add(1, GT, 0, 0, 0, 0, 1, 0, 0);
      add(1, GT, 0, 0, 0, 0, 2, 0, 0);
      add(0, LT, 0, 0, 0, 0, 2, 0, 0);
      add(0, LT, 0, 0, 0, 0, 2, 0, 0);
      add(0, LT, 0, 0, 0, 0, 2, 0, 0);
      add(1, GT, 0, 0, 0, 0, 3, 0, 0);
      add(1, GT, 0, 2, 1, 0, 4, 0, 0);
      add(0, NO, 1, 0, 0, 0, 0, 0, 0);
      // malformed samples
      add(1, GT, 0, 0, 0, 0, 1, 0, 0);
      add(1, GT, 0, 0, 0, 0, 2, 0, 0);
      add(1, 3'b011, 0, 0, 0, 0, 2, 0, 1);
      add(1, GT, 0, 0, 0, 0, 3, 0, 1);
      add(1, GT, 0, 0, 0, 0, 4, 0, 1);
      add(1, GT, 0, 0, 0, 0, 5, 0, 1);
      add(1, GT, 0, 2, 1, 0, 6, 0, 1);
      add(1, NO, 0, 2, 0, 0, 6, 0, 1);
      add(1, LT, 0, 2, 0, 0, 6, 1, 1);
      add(1, LT, 0, 2, 0, 0, 6, 2, 1);
      add(1, LT, 0, 2, 0, 0, 6, 3, 1);
      add(1, LT, 0, 3, 1, 0, 6, 4, 1);
      add(1, 3'b111, 0, 3, 0, 0, 6, 4, 1);
      add(1, LT, 0, 3, 0, 0, 6, 5, 1);
      add(1, EQ, 1, 0, 0, 0, 0, 0, 0);

      // power-on reset
      #2;
      chk("por_state", state, 0);
      chk("por_dec", {eq_q, gt_q, lt_q}, 0);
      chk("por_err", err, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].f, tbl[i].c);
         chk($sformatf("v%0d_state", i), state, tbl[i].st);
         chk($sformatf("v%0d_dec", i), {eq_q, gt_q, lt_q}, decode(tbl[i].st));
         chk($sformatf("v%0d_chg", i), chg, tbl[i].chg);
         chk($sformatf("v%0d_eq_cnt", i), eq_cnt, tbl[i].ec);
         chk($sformatf("v%0d_gt_cnt", i), gt_cnt, tbl[i].gc);
         chk($sformatf("v%0d_lt_cnt", i), lt_cnt, tbl[i].lc);
         chk($sformatf("v%0d_err", i), err, tbl[i].e);
      end

      // saturation with CNT_W=3
      for (int i = 1; i <= 10; i++) begin
         step(1, LT, 0);
         chk($sformatf("sat%0d_lt_cnt", i), lt_cnt_s, (i > 7) ? 7 : i);
         chk($sformatf("sat%0d_state", i), state_s, (i >= 4) ? 3 : 0);
         chk($sformatf("sat%0d_lt_cnt_w8", i), lt_cnt, i);
      end
      step(0, NO, 1);
      chk("sat_clear", lt_cnt_s, 0);

      // PERSIST=1 qualifies on every differing sample
      step(1, EQ, 0);
      chk("p1_eq_state", state_p, 1);
      chk("p1_eq_chg", chg_p, 1);
      step(1, EQ, 0);
      chk("p1_eq2_state", state_p, 1);
      chk("p1_eq2_chg", chg_p, 0);
      step(1, GT, 0);
      chk("p1_gt_state", state_p, 2);
      chk("p1_gt_chg", chg_p, 1);
      step(1, 3'b101, 0);
      chk("p1_bad_state", state_p, 2);
      chk("p1_bad_chg", chg_p, 0);
      chk("p1_bad_err", err_p, 1);
      step(1, LT, 0);
      chk("p1_lt_state", state_p, 3);
      chk("p1_lt_chg", chg_p, 1);
      chk("p1_lt_dec", {eq_q_p, gt_q_p, lt_q_p}, 3'b001);
      step(0, NO, 1);

      // asynchronous reset mid-run, sampled between clock edges
      step(1, LT, 0);
      step(1, LT, 0);
      chk("pre_rst_lt_cnt", lt_cnt, 2);
      @(negedge clk);
      #2;
      rst = 1'b1;
      cmp_valid = 1'($urandom);
      {Equal, Greater, Lesser} = 3'($urandom);
      clear = 1'($urandom);
      #1;
      chk("arst_state", state, 0);
      chk("arst_dec", {eq_q, gt_q, lt_q}, 0);
      chk("arst_chg", chg, 0);
      chk("arst_cnts", {eq_cnt, gt_cnt, lt_cnt}, 0);
      chk("arst_err", err, 0);
      chk("arst_p1_state", state_p, 0);
      @(negedge clk);
      rst = 1'b0;
      cmp_valid = 1'b0;
      clear = 1'b0;
      // partial run discarded: two more LT must not qualify
      step(1, LT, 0);
      step(1, LT, 0);
      chk("post_rst_state", state, 0);
      chk("post_rst_lt_cnt", lt_cnt, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
